// File: rtl/kbd_pkg.sv
// Shared constants and types for the keyboard-driven cursor controller:
// scancodes, colours, FSM encoding and the buffered event record.
package kbd_pkg;

  localparam logic [7:0] KEY_F = 8'h2B;
  localparam logic [7:0] KEY_Q = 8'h15;
  localparam logic [7:0] KEY_H = 8'h33;
  localparam logic [7:0] KEY_X = 8'h22;
  localparam logic [7:0] KEY_R = 8'h2D;
  localparam logic [7:0] KEY_G = 8'h34;
  localparam logic [7:0] KEY_B = 8'h32;
  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_I = 8'h43;
  localparam logic [7:0] KEY_K = 8'h42;
  localparam logic [7:0] KEY_J = 8'h3B;
  localparam logic [7:0] KEY_L = 8'h4B;

  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_MOVE   = 2'd1,
    CLS_CHAR   = 2'd2,
    CLS_COLOUR = 2'd3
  } evt_class_t;

  typedef struct packed {
    evt_class_t cls;
    logic [7:0] code;
  } event_t;

  // Per-axis cursor step produced by a move key.
  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_INC  = 2'b01,
    STEP_DEC  = 2'b11
  } step_t;

endpackage

// File: rtl/kbd_evt_decode.sv
// Combinational event decoder: scancode plus class flags to class, glyph,
// colour and cursor step. A scancode outside its class table yields CLS_NONE.
module kbd_evt_decode
  import kbd_pkg::*;
(
  input  logic [7:0]  code,
  input  logic        char_check,
  input  logic        colour_check,
  input  logic        move_check,
  output evt_class_t  cls,
  output logic [1:0]  glyph,
  output logic [2:0]  colour,
  output step_t       dx,
  output step_t       dy
);

  always_comb begin
    cls    = CLS_NONE;
    glyph  = 2'd0;
    colour = COL_WHITE;
    dx     = STEP_NONE;
    dy     = STEP_NONE;
    // Flag priority is move, then glyph, then colour.
    if (move_check) begin
      cls = CLS_MOVE;
      case (code)
        KEY_I:   dy  = STEP_DEC;
        KEY_K:   dy  = STEP_INC;
        KEY_J:   dx  = STEP_DEC;
        KEY_L:   dx  = STEP_INC;
        default: cls = CLS_NONE;
      endcase
    end else if (char_check) begin
      cls = CLS_CHAR;
      case (code)
        KEY_F:   glyph = 2'd0;
        KEY_Q:   glyph = 2'd1;
        KEY_H:   glyph = 2'd2;
        KEY_X:   glyph = 2'd3;
        default: cls   = CLS_NONE;
      endcase
    end else if (colour_check) begin
      cls = CLS_COLOUR;
      case (code)
        KEY_R:   colour = COL_RED;
        KEY_G:   colour = COL_GREEN;
        KEY_B:   colour = COL_BLUE;
        KEY_W:   colour = COL_WHITE;
        default: cls    = CLS_NONE;
      endcase
    end
  end

endmodule

// File: rtl/kbd_cursor_ctrl.sv
// Cursor/glyph/colour state for the character display, issuing one buffer
// write per glyph key, with a one-deep buffer for keys arriving mid-write.
//
// Write handshake: wr_req rises with wr_x/wr_y/wr_char/wr_colour valid and
// holds them frozen until wr_ack is sampled high at a clock edge; wr_req
// falls on that edge. wr_ack while wr_req is low has no effect.
module kbd_cursor_ctrl
  import kbd_pkg::*;
#(
  parameter int COLS  = 16,
  parameter int ROWS  = 12,
  parameter int COL_W = 4,
  parameter int ROW_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       scancode,
  input  logic             key_valid,
  input  logic             char_check,
  input  logic             colour_check,
  input  logic             move_check,
  output logic [COL_W-1:0] cur_x,
  output logic [ROW_W-1:0] cur_y,
  output logic [1:0]       cur_char,
  output logic [2:0]       cur_colour,
  output logic             wr_req,
  output logic [COL_W-1:0] wr_x,
  output logic [ROW_W-1:0] wr_y,
  output logic [1:0]       wr_char,
  output logic [2:0]       wr_colour,
  input  logic             wr_ack,
  output logic             drop
);

  state_t     state, state_nx;
  event_t     buf_evt;
  logic       buf_full;

  evt_class_t live_cls, buf_cls, sel_cls;
  logic [1:0] live_glyph, buf_glyph, sel_glyph;
  logic [2:0] live_colour, buf_colour, sel_colour;
  step_t      live_dx, live_dy, buf_dx, buf_dy, sel_dx, sel_dy;

  logic       live_ok, use_buf, do_evt, buf_load, buf_clear, drop_nx, wr_done;
  logic [COL_W-1:0] x_nx;
  logic [ROW_W-1:0] y_nx;

  kbd_evt_decode u_live_dec (
    .code         (scancode),
    .char_check   (char_check),
    .colour_check (colour_check),
    .move_check   (move_check),
    .cls          (live_cls),
    .glyph        (live_glyph),
    .colour       (live_colour),
    .dx           (live_dx),
    .dy           (live_dy)
  );

  // The buffer stores the resolved class, so it is re-expanded to one flag.
  kbd_evt_decode u_buf_dec (
    .code         (buf_evt.code),
    .char_check   (buf_evt.cls == CLS_CHAR),
    .colour_check (buf_evt.cls == CLS_COLOUR),
    .move_check   (buf_evt.cls == CLS_MOVE),
    .cls          (buf_cls),
    .glyph        (buf_glyph),
    .colour       (buf_colour),
    .dx           (buf_dx),
    .dy           (buf_dy)
  );

  assign live_ok    = key_valid && (live_cls != CLS_NONE);
  assign use_buf    = (state == IDLE) && buf_full;
  assign sel_cls    = use_buf ? buf_cls    : live_cls;
  assign sel_glyph  = use_buf ? buf_glyph  : live_glyph;
  assign sel_colour = use_buf ? buf_colour : live_colour;
  assign sel_dx     = use_buf ? buf_dx     : live_dx;
  assign sel_dy     = use_buf ? buf_dy     : live_dy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    do_evt    = 1'b0;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    drop_nx   = 1'b0;
    wr_done   = 1'b0;
    case (state)
      IDLE: begin
        if (buf_full) begin
          do_evt    = 1'b1;
          buf_load  = live_ok;
          buf_clear = !live_ok;
        end else if (live_ok) begin
          do_evt = 1'b1;
        end
        if (do_evt && sel_cls == CLS_CHAR) state_nx = WRITE;
      end
      WRITE: begin
        if (live_ok) begin
          if (buf_full) drop_nx  = 1'b1;
          else          buf_load = 1'b1;
        end
        if (wr_ack) begin
          wr_done  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Wrap-around cursor arithmetic.
  always_comb begin
    x_nx = cur_x;
    y_nx = cur_y;
    case (sel_dx)
      STEP_INC: x_nx = (cur_x == COL_W'(COLS - 1)) ? '0 : cur_x + 1'b1;
      STEP_DEC: x_nx = (cur_x == '0) ? COL_W'(COLS - 1) : cur_x - 1'b1;
      default:  x_nx = cur_x;
    endcase
    case (sel_dy)
      STEP_INC: y_nx = (cur_y == ROW_W'(ROWS - 1)) ? '0 : cur_y + 1'b1;
      STEP_DEC: y_nx = (cur_y == '0) ? ROW_W'(ROWS - 1) : cur_y - 1'b1;
      default:  y_nx = cur_y;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_x      <= '0;
      cur_y      <= '0;
      cur_char   <= 2'd0;
      cur_colour <= COL_WHITE;
      wr_req     <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_char    <= 2'd0;
      wr_colour  <= 3'd0;
      drop       <= 1'b0;
      buf_full   <= 1'b0;
      buf_evt    <= '0;
    end else begin
      drop <= drop_nx;
      if (buf_load) begin
        buf_evt.cls  <= live_cls;
        buf_evt.code <= scancode;
        buf_full     <= 1'b1;
      end else if (buf_clear) begin
        buf_full <= 1'b0;
      end
      if (wr_done) wr_req <= 1'b0;
      if (do_evt) begin
        case (sel_cls)
          CLS_MOVE: begin
            cur_x <= x_nx;
            cur_y <= y_nx;
          end
          CLS_COLOUR: cur_colour <= sel_colour;
          CLS_CHAR: begin
            // The write carries the cursor and colour as they were before this key.
            cur_char  <= sel_glyph;
            wr_req    <= 1'b1;
            wr_x      <= cur_x;
            wr_y      <= cur_y;
            wr_char   <= sel_glyph;
            wr_colour <= cur_colour;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
